mem_req_arbiter: RTL
====================

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter MEM_LATENCY, default 4, fixed cycles from accepted read request to its mem_resp_valid (legal range 1..16).
REQ-002 Parameter BLOCK_ADDR_WIDTH, default `MAIN_MEM_BLOCK_ADDR_WIDTH; BLOCK_DATA_WIDTH, default `MAIN_MEM_BLOCK_DATA_WIDTH.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst_aL  in  1  reset, asynchronous, active-low.
REQ-005 i_req_valid  in  1  icache refill read request; i_req_block_addr  in  BLOCK_ADDR_WIDTH.
REQ-006 i_req_ready  out  1  icache request accepted this cycle.
REQ-007 i_flush  in  1  fetch redirect: discard all in-flight icache reads.
REQ-008 i_resp_valid  out  1; i_resp_block_data  out  BLOCK_DATA_WIDTH  icache refill data.
REQ-009 d_req_valid  in  1; d_req_type  in  1 (0 read, 1 write); d_req_block_addr  in  BLOCK_ADDR_WIDTH; d_req_block_data  in  BLOCK_DATA_WIDTH.
REQ-010 d_req_ready  out  1; d_resp_valid  out  1; d_resp_block_data  out  BLOCK_DATA_WIDTH.
REQ-011 mem_req_valid  out  1; mem_req_type  out  1; mem_req_block_addr  out  BLOCK_ADDR_WIDTH; mem_req_block_data  out  BLOCK_DATA_WIDTH; mem_req_ready  in  1.
REQ-012 mem_resp_valid  in  1; mem_resp_block_data  in  BLOCK_DATA_WIDTH.
REQ-013 protocol_err  out  1  sticky: unexpected memory response seen.

Function
REQ-014 Handshake: transfer occurs when valid & ready in same cycle; requesters hold valid and payload stable until accepted; ready never gates valid.
REQ-015 mem_req_valid = (i_req_valid & ~i_flush) | d_req_valid; payload muxed from granted requester combinationally.
REQ-016 Grant: only one requester; on sole request, that requester; on conflict, requester not granted most recently (last_grant register).
REQ-017 i_req_ready = mem_req_ready & grant_i & ~i_flush; d_req_ready = mem_req_ready & grant_d.
REQ-018 last_grant updates only on an accepted transfer; unaccepted grants do not rotate priority.
REQ-019 Tag pipeline: MEM_LATENCY-stage shift register, entry {valid, dst(I/D), killed}, advances every cycle.
REQ-020 Accepted read pushes {1, dst, 0} into stage 0; accepted write or no transfer pushes valid=0; writes produce no response.
REQ-021 Routing: when mem_resp_valid, final-stage entry valid & ~killed routes data to dst; i_resp/d_resp valid same cycle as mem_resp_valid (zero added latency), data passed through unregistered.
REQ-022 Final-stage killed entry: response dropped, no resp_valid, no error.
REQ-023 mem_resp_valid with final-stage valid=0, or final-stage valid=1 without mem_resp_valid: protocol_err set to 1, held until reset.
REQ-024 i_flush: every in-flight I entry (all stages, incl. the one shifting in this cycle) sets killed=1; D entries untouched; no icache request accepted that cycle.
REQ-025 Throughput: one accepted request per cycle, up to MEM_LATENCY reads outstanding, no bubbles.
REQ-026 Outputs i_resp_valid, d_resp_valid never both 1 in a cycle.

Reset
REQ-027 rst_aL low asynchronously clears: all tag stages valid=0/killed=0, last_grant=D (so I wins first conflict), protocol_err=0.
REQ-028 During reset all ready and resp_valid outputs are 0; mem_req_valid is 0.
REQ-029 Responses arriving after reset for pre-reset requests set protocol_err (REQ-023); memory is reset with the arbiter.

Verification (MEM_LATENCY=4)
REQ-030 I read addr 0x100 accepted cycle 10, mem returns 0xAB.. at 14 -> i_resp_valid=1 at 14 only, data 0xAB.., d_resp_valid=0.
REQ-031 I and D reads both valid continuously from cycle 0, mem_req_ready=1 -> grants I,D,I,D on cycles 0..3; responses cycles 4..7 alternate I,D.
REQ-032 mem_req_ready=0 cycles 0..2 with both valid -> no transfer, last_grant unchanged; cycle 3 ready=1 -> I granted.
REQ-033 D write at cycle 5 -> mem_req_type=1, no resp at cycle 9; any mem_resp_valid at 9 -> protocol_err=1 at 10.
REQ-034 I reads accepted cycles 0,1; i_flush at cycle 2 -> mem responses at 4,5 dropped, i_resp_valid=0, protocol_err=0; D read at 3 still returned at 7.
REQ-035 rst_aL low at cycle 2 with 2 reads outstanding -> outputs 0 immediately; after release last_grant=D, tag pipe empty.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter
//
// Shares a single main-memory request port between the instruction cache
// (refill reads only) and the data cache (reads and writes). Memory answers
// every read after a fixed MEM_LATENCY cycles. A tag pipeline of the same
// depth records where each outstanding read must be returned.
//
// Arbitration: a lone requester is granted. When both request, the one that
// did not win the most recent accepted transfer is granted. Only accepted
// transfers move the priority.
//
// A fetch redirect (i_flush) kills every icache read still in flight. Memory
// still returns the data, but it is dropped here. An unexpected memory
// response, or a missing one, sets a sticky protocol error.
//
// Ports
//   clk                  sole clock, rising edge
//   rst_aL               asynchronous active-low reset
//   i_req_valid/_ready   icache refill read request handshake
//   i_req_block_addr     icache block address
//   i_flush              discard every in-flight icache read
//   i_resp_valid/_data   icache refill data (same cycle as memory response)
//   d_req_valid/_ready   dcache request handshake
//   d_req_type           0 = read, 1 = write
//   d_req_block_addr     dcache block address
//   d_req_block_data     dcache write data
//   d_resp_valid/_data   dcache read data (same cycle as memory response)
//   mem_req_*            request to main memory, mem_req_ready from memory
//   mem_resp_valid/_data read data from main memory
//   protocol_err         sticky, set on an unexpected or missing response
// -----------------------------------------------------------------------------

`ifndef MAIN_MEM_BLOCK_ADDR_WIDTH
`define MAIN_MEM_BLOCK_ADDR_WIDTH 32
`endif
`ifndef MAIN_MEM_BLOCK_DATA_WIDTH
`define MAIN_MEM_BLOCK_DATA_WIDTH 64
`endif

module mem_req_arbiter #(
    // Fixed read latency of main memory in cycles. Legal range is 1..16.
    parameter int MEM_LATENCY      = 4,
    parameter int BLOCK_ADDR_WIDTH = `MAIN_MEM_BLOCK_ADDR_WIDTH,
    parameter int BLOCK_DATA_WIDTH = `MAIN_MEM_BLOCK_DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_aL,

    input  logic                        i_req_valid,
    input  logic [BLOCK_ADDR_WIDTH-1:0] i_req_block_addr,
    output logic                        i_req_ready,
    input  logic                        i_flush,
    output logic                        i_resp_valid,
    output logic [BLOCK_DATA_WIDTH-1:0] i_resp_block_data,

    input  logic                        d_req_valid,
    input  logic                        d_req_type,
    input  logic [BLOCK_ADDR_WIDTH-1:0] d_req_block_addr,
    input  logic [BLOCK_DATA_WIDTH-1:0] d_req_block_data,
    output logic                        d_req_ready,
    output logic                        d_resp_valid,
    output logic [BLOCK_DATA_WIDTH-1:0] d_resp_block_data,

    output logic                        mem_req_valid,
    output logic                        mem_req_type,
    output logic [BLOCK_ADDR_WIDTH-1:0] mem_req_block_addr,
    output logic [BLOCK_DATA_WIDTH-1:0] mem_req_block_data,
    input  logic                        mem_req_ready,

    input  logic                        mem_resp_valid,
    input  logic [BLOCK_DATA_WIDTH-1:0] mem_resp_block_data,

    output logic                        protocol_err
);

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    // Destination encoding held in the tag pipeline.
    localparam logic DST_I = 1'b0;
    localparam logic DST_D = 1'b1;

    localparam int L = MEM_LATENCY;

    grant_e         last_grant_q;
    grant_e         last_grant_d;

    // Tag pipeline, one bit per stage for each field. Stage L-1 is the one
    // that lines up with the memory response.
    logic [L-1:0]   vld_q;
    logic [L-1:0]   vld_d;
    logic [L-1:0]   dst_q;
    logic [L-1:0]   dst_d;
    logic [L-1:0]   kill_q;
    logic [L-1:0]   kill_d;

    logic           err_q;
    logic           err_d;

    logic           i_eff_s;
    logic           grant_i_s;
    logic           grant_d_s;
    logic           xfer_s;
    logic           push_rd_s;
    logic           push_dst_s;
    logic [L:0]     vld_in_s;
    logic [L:0]     dst_in_s;
    logic [L:0]     kill_in_s;
    logic           fin_vld_s;
    logic           fin_dst_s;
    logic           fin_kill_s;
    logic           fin_live_s;

    // A flushed icache request does not compete for the memory port.
    assign i_eff_s   = i_req_valid & ~i_flush;
    assign grant_i_s = i_eff_s & (~d_req_valid | (last_grant_q == GRANT_D));
    assign grant_d_s = d_req_valid & ~grant_i_s;

    // Every handshake output is forced low while reset is asserted.
    assign mem_req_valid = rst_aL & (i_eff_s | d_req_valid);
    assign i_req_ready   = rst_aL & mem_req_ready & grant_i_s & ~i_flush;
    assign d_req_ready   = rst_aL & mem_req_ready & grant_d_s;
    assign xfer_s        = mem_req_valid & mem_req_ready;

    // Request payload mux, following the grant.
    always_comb begin
        mem_req_type       = 1'b0;
        mem_req_block_addr = i_req_block_addr;
        mem_req_block_data = {BLOCK_DATA_WIDTH{1'b0}};
        if (grant_i_s) begin
            mem_req_type       = 1'b0;
            mem_req_block_addr = i_req_block_addr;
            mem_req_block_data = {BLOCK_DATA_WIDTH{1'b0}};
        end else begin
            mem_req_type       = d_req_type;
            mem_req_block_addr = d_req_block_addr;
            mem_req_block_data = d_req_block_data;
        end
    end

    // Priority only moves on an accepted transfer.
    always_comb begin
        last_grant_d = last_grant_q;
        if (xfer_s) begin
            last_grant_d = grant_i_s ? GRANT_I : GRANT_D;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Only accepted reads enter the tag pipeline; writes and idle cycles
    // push an empty slot.
    assign push_rd_s  = xfer_s & (grant_i_s | (d_req_type == 1'b0));
    assign push_dst_s = grant_i_s ? DST_I : DST_D;

    // Bit k of the *_in vectors is the value shifting into stage k this
    // cycle, so the flush kill is applied to entries as they move.
    assign vld_in_s  = {vld_q,  push_rd_s};
    assign dst_in_s  = {dst_q,  push_dst_s};
    assign kill_in_s = {kill_q, 1'b0};

    assign vld_d  = vld_in_s[L-1:0];
    assign dst_d  = dst_in_s[L-1:0];
    assign kill_d = kill_in_s[L-1:0]
                  | ({L{i_flush}} & vld_in_s[L-1:0] & ~dst_in_s[L-1:0]);

    assign fin_vld_s  = vld_q[L-1];
    assign fin_dst_s  = dst_q[L-1];
    assign fin_kill_s = kill_q[L-1];
    assign fin_live_s = rst_aL & mem_resp_valid & fin_vld_s & ~fin_kill_s;

    // An icache entry being consumed in the same cycle as a flush is also
    // in flight, so it is dropped as well.
    assign i_resp_valid      = fin_live_s & (fin_dst_s == DST_I) & ~i_flush;
    assign d_resp_valid      = fin_live_s & (fin_dst_s == DST_D);
    assign i_resp_block_data = mem_resp_block_data;
    assign d_resp_block_data = mem_resp_block_data;

    // Response without a tag, or tag without a response, are both errors.
    // A killed tag still expects its response.
    assign err_d        = err_q | (mem_resp_valid ^ fin_vld_s);
    assign protocol_err = err_q;

    // State registers: grant history, tag pipeline, sticky error.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            last_grant_q <= GRANT_D;
            vld_q        <= {L{1'b0}};
            dst_q        <= {L{1'b0}};
            kill_q       <= {L{1'b0}};
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            vld_q        <= vld_d;
            dst_q        <= dst_d;
            kill_q       <= kill_d;
            err_q        <= err_d;
        end
    end

endmodule
